uart_rx: RTL and testbench

- Asynchronous serial receiver; consumes the 8N1 line that uart_tx drives and delivers parallel bytes.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1); idle line is high.
- Runs on the same system clock as uart_tx. Driven by an oversampling tick from the shared baud generator: OVERSAMPLE pulses per bit time.
- Sits between the off-chip rx pin and the consumer logic: command parser, RX FIFO or loopback checker.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default frame geometry and line levels.
// The transmitter and receiver use the same state encoding.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input.
// It resets to RST_VAL so that an idle-high line shows no spurious edge after reset.
module uart_rx_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= {STAGES{RST_VAL}};
      else     sync_q <= {sync_q[STAGES-2:0], async_i};
   end

   assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by an oversampling tick.
// It validates the start bit at mid-bit, then samples each data bit and the stop bit at their centres.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int CNT_W  = $clog2(OVERSAMPLE);
   localparam int BIDX_W = $clog2(DATA_BITS) + 1;

   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIDX_W-1:0] BIT_LAST  = BIDX_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     tick_q, tick_d;
   logic [BIDX_W-1:0]    bidx_q, bidx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 prev_q, prev_d;
   logic                 rx_s;

   uart_rx_sync #(.STAGES(2), .RST_VAL(1'b1)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (rx),
      .sync_o  (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         prev_q  <= prev_d;
      end
   end

   // Pulses default low every clk, so they self-clear even without a tick.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      prev_d  = prev_q;

      if (sample_tick) begin
         prev_d = rx_s;
         case (state_q)
            IDLE: begin
               // A falling edge is required, so a held-low break cannot retrigger.
               if (prev_q && (rx_s == START_BIT)) begin
                  tick_d  = '0;
                  state_d = START;
               end
            end
            START: begin
               if (tick_q == HALF_LAST) begin
                  if (rx_s == START_BIT) begin
                     tick_d  = '0;
                     bidx_d  = '0;
                     state_d = DATA;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            DATA: begin
               if (tick_q == FULL_LAST) begin
                  for (int i = 0; i < DATA_BITS; i++)
                     if (bidx_q == BIDX_W'(i)) shift_d[i] = rx_s;
                  tick_d = '0;
                  if (bidx_q == BIT_LAST) state_d = STOP;
                  else                    bidx_d  = bidx_q + 1'b1;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            STOP: begin
               if (tick_q == FULL_LAST) begin
                  if (rx_s == STOP_BIT) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
                  tick_d  = '0;
                  state_d = IDLE;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: a line model serializes bytes and a queue holds the expected stream.
module tb_uart_rx;

   localparam int OS      = 16;
   localparam int DIV     = 4;          // clks per sample_tick
   localparam int BIT_CLK = OS * DIV;   // clks per bit time

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, rx_busy;

   int   checks = 0;
   int   errors = 0;
   int   valid_cnt = 0;
   int   ferr_cnt = 0;
   bit   busy_seen = 0;
   bit   tick_en = 1;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         div = (div + 1) % DIV;
         sample_tick = (div == 0) && tick_en;
      end
   end

   // Monitor: collects every delivered byte and checks pulse shape.
   initial begin
      bit pv, pf;
      pv = 0; pf = 0;
      forever begin
         @(negedge clk);
         if (rx_busy) busy_seen = 1;
         if (rx_valid) begin got_q.push_back(rx_data); valid_cnt++; end
         if (frame_err) ferr_cnt++;
         if (rx_valid || frame_err) begin
            checks++;
            if ((rx_valid && pv) || (frame_err && pf) || (rx_valid && frame_err)) begin
               errors++;
               $display("FAIL pulse_shape valid=%b ferr=%b prev_valid=%b prev_ferr=%b", rx_valid, frame_err, pv, pf);
            end
         end
         pv = rx_valid; pf = frame_err;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required to finish");
      $fatal(1, "timeout");
   end

   // Line model: start bit, 8 data bits LSB first, stop bit; each held one bit time.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      if (stop) exp_q.push_back(b);
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (BIT_CLK) @(negedge clk);
      end
   endtask

   task automatic idle(input int clks);
      rx = 1'b1;
      repeat (clks) @(negedge clk);
   endtask

   task automatic compare_stream(input string name);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s_count got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_byte[%0d] got %h, expected %h", name, i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'h0) begin
         errors++;
         $display("FAIL reset_outputs got data=%h v=%b fe=%b busy=%b, expected all 0", rx_data, rx_valid, frame_err, rx_busy);
      end
      rst = 1'b0;
      idle(2 * BIT_CLK);
      checks++;
      if (rx_busy !== 1'b0 || valid_cnt != 0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b valids=%0d, expected 0/0", rx_busy, valid_cnt);
      end
   endtask

   task automatic test_frame_a5();
      int f0;
      f0 = ferr_cnt; busy_seen = 0;
      send_frame(8'hA5, 1'b1);
      idle(BIT_CLK);
      compare_stream("a5");
      checks++;
      if (ferr_cnt != f0 || rx_data !== 8'hA5 || rx_busy !== 1'b0 || !busy_seen) begin
         errors++;
         $display("FAIL a5_status got fe=%0d data=%h busy=%b seen=%b, expected 0 A5 0 1", ferr_cnt - f0, rx_data, rx_busy, busy_seen);
      end
   endtask

   task automatic test_glitch();
      int v0, f0;
      v0 = valid_cnt; f0 = ferr_cnt; busy_seen = 0;
      rx = 1'b0;
      repeat (3 * DIV) @(negedge clk);
      idle(BIT_CLK);
      checks++;
      if (valid_cnt != v0 || ferr_cnt != f0 || !busy_seen || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch got valids=%0d ferrs=%0d seen=%b busy=%b, expected 0 0 1 0", valid_cnt - v0, ferr_cnt - f0, busy_seen, rx_busy);
      end
      send_frame(8'h3C, 1'b1);
      idle(BIT_CLK);
      compare_stream("glitch_next");
   endtask

   task automatic test_frame_err();
      int v0, f0;
      logic [7:0] b;
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h81, 1'b0);
      busy_seen = 0;
      rx = 1'b0;
      repeat (40 * BIT_CLK) @(negedge clk);
      checks++;
      if (ferr_cnt - f0 != 1 || valid_cnt != v0 || rx_data !== 8'h3C) begin
         errors++;
         $display("FAIL frame_err got ferrs=%0d valids=%0d data=%h, expected 1 0 3C", ferr_cnt - f0, valid_cnt - v0, rx_data);
      end
      checks++;
      if (busy_seen || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL break_retrigger got seen=%b busy=%b, expected 0 0", busy_seen, rx_busy);
      end
      idle(2 * BIT_CLK);
      b = 8'($urandom);
      send_frame(b, 1'b1);
      idle(BIT_CLK);
      compare_stream("after_break");
   endtask

   task automatic test_back_to_back();
      int f0;
      f0 = ferr_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(BIT_CLK);
      compare_stream("b2b");
      checks++;
      if (ferr_cnt != f0) begin
         errors++;
         $display("FAIL b2b_ferr got %0d, expected 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int v0, f0;
      logic [9:0] f;
      v0 = valid_cnt; f0 = ferr_cnt;
      f = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx = f[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rx = f[5];
      repeat (BIT_CLK / 2) @(negedge clk);
      rst = 1'b1; rx = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'h0) begin
         errors++;
         $display("FAIL midframe_reset got data=%h v=%b fe=%b busy=%b, expected all 0", rx_data, rx_valid, frame_err, rx_busy);
      end
      rst = 1'b0;
      idle(2 * BIT_CLK);
      checks++;
      if (valid_cnt != v0 || ferr_cnt != f0 || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL partial_discard got valids=%0d ferrs=%0d busy=%b, expected 0 0 0", valid_cnt - v0, ferr_cnt - f0, rx_busy);
      end
      send_frame(8'hC3, 1'b1);
      idle(BIT_CLK);
      compare_stream("after_reset");
   endtask

   // Transmitter model: one bit per 16 sample ticks, counted off the shared tick.
   task automatic test_loopback();
      logic [7:0] pat [4];
      logic [9:0] f;
      pat = '{8'h00, 8'h55, 8'hAA, 8'hFF};
      for (int k = 0; k < 4; k++) begin
         f = {1'b1, pat[k], 1'b0};
         exp_q.push_back(pat[k]);
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            for (int t = 0; t < OS; t++) begin
               do @(posedge clk); while (!sample_tick);
            end
         end
      end
      idle(BIT_CLK);
      compare_stream("loopback");
   endtask

   task automatic test_random();
      int f0;
      logic [7:0] b;
      f0 = ferr_cnt;
      for (int k = 0; k < 12; k++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2 * BIT_CLK));
      end
      idle(BIT_CLK);
      compare_stream("random");
      checks++;
      if (ferr_cnt != f0) begin
         errors++;
         $display("FAIL random_ferr got %0d, expected 0", ferr_cnt - f0);
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
      test_loopback();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
